speed_pickup_renderer: RTL
==========================

Name: speed_pickup_renderer

Overview:
- Upstream driver and consumer of the 280-entry speed power-up sprite ROM (SPR_W×SPR_H, 4-bit palette index, 1-clock registered read).
- Tracks the pickup lifecycle: spawn, visible, blinking, expired or collected.
- Generates ROM read addresses from the VGA scan position and aligns the returned index with the ROM's one-cycle latency.
- Emits a per-pixel draw flag and palette index for the colour mapper, plus the player speed-boost flag.

Parameters:
- SPR_W, 14, sprite width in pixels.
- SPR_H, 20, sprite height in pixels; SPR_W*SPR_H must equal 280.
- TRANSP_IDX, 0, palette index treated as transparent.
- LIFETIME_FRAMES, 600, total frames on screen before expiry.
- BLINK_FRAMES, 120, final frames of lifetime spent blinking; must be less than LIFETIME_FRAMES.
- BLINK_PERIOD, 8, frames per blink half-phase.
- BOOST_FRAMES, 300, boost duration loaded on collection.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset, asynchronous assert, active-low.
- frame_start  in  1  one-cycle pulse per frame (vsync edge).
- spawn  in  1  one-cycle pulse: place pickup.
- spawn_x  in  10  spawn top-left X, sampled on spawn.
- spawn_y  in  10  spawn top-left Y, sampled on spawn.
- collected  in  1  one-cycle pulse from collision logic.
- DrawX  in  10  current scan X (0–639).
- DrawY  in  10  current scan Y (0–479).
- rom_addr  out  19  sprite ROM read address.
- rom_data  in  4  sprite ROM output, valid one clock after rom_addr.
- pixel_on  out  1  draw pickup at aligned pixel.
- pixel_idx  out  4  palette index, 0 when pixel_on=0.
- active  out  1  pickup present (VISIBLE or BLINKING).
- speed_boost  out  1  boost in effect.

Behaviour:
- Reset (Reset_n low, async):
  - State IDLE; pos_x=pos_y=0; life_cnt=0; blink_cnt=0; blink_phase=1; boost_cnt=0.
  - Pipeline flags cleared; outputs pixel_on=0, pixel_idx=0, active=0, speed_boost=0.
  - rom_addr=0 while in reset.
- FSM states: IDLE, VISIBLE, BLINKING.
  - IDLE + spawn -> VISIBLE; latch spawn_x/y; life_cnt=LIFETIME_FRAMES.
  - VISIBLE: each frame_start decrements life_cnt; when the decremented value equals BLINK_FRAMES -> BLINKING with blink_phase=1 and blink_cnt=BLINK_PERIOD.
  - BLINKING: each frame_start decrements life_cnt and blink_cnt; when blink_cnt reaches 0, toggle blink_phase and reload BLINK_PERIOD. When life_cnt reaches 0 -> IDLE.
  - VISIBLE/BLINKING + collected -> IDLE; boost_cnt=BOOST_FRAMES.
  - collected in IDLE is ignored.
  - spawn in VISIBLE/BLINKING re-latches position and restarts at VISIBLE with a full lifetime.
- Simultaneous events:
  - collected + frame_start: collection wins; boost_cnt is loaded and not decremented that cycle.
  - collected + spawn while active: boost is loaded and the new spawn takes effect (-> VISIBLE).
  - spawn + frame_start: spawn wins; no decrement.
- Boost: boost_cnt decrements on frame_start, saturating at 0. speed_boost = (boost_cnt != 0), registered.
- Render, stage 0 (combinational from DrawX/DrawY):
  - in_box = DrawX≥pos_x && DrawX<pos_x+SPR_W && DrawY≥pos_y && DrawY<pos_y+SPR_H.
  - Sums are computed in 11 bits, so no wrap for positions near 639/479; a partially off-screen sprite is clipped.
  - rom_addr = in_box ? (DrawY−pos_y)*SPR_W + (DrawX−pos_x) : 0, zero-extended to 19 bits; range 0–279.
- Render, stage 1: register hit_d = in_box && (state==VISIBLE || (state==BLINKING && blink_phase)).
  - pixel_on = hit_d && rom_data≠TRANSP_IDX.
  - pixel_idx = pixel_on ? rom_data : 0.
  - Latency from DrawX/DrawY to pixel_on is exactly 1 clock, matching ROM latency.
- Reset mid-frame clears hit_d immediately; no stale pixel is drawn.

Optional Feature:
- Macro SPEED_PICKUP_STACK_EN.
- Defined: collection while speed_boost=1 adds BOOST_FRAMES to boost_cnt, saturating at 2*BOOST_FRAMES. boost_cnt width is sized for 2*BOOST_FRAMES.
- Undefined: collection always reloads boost_cnt=BOOST_FRAMES, with no stacking.

Test Plan:
- Spawn at (100,50); scan DrawX=100..113, DrawY=50:
  - rom_addr=0..13 in the same cycle.
  - pixel_on follows one clock later for non-zero rom_data.
  - pixel_idx equals rom_data.
- Same sprite, DrawX=113, DrawY=69 -> rom_addr=279. DrawX=114 -> rom_addr=0, pixel_on=0 next clock.
- Spawn, then 480 frame_starts -> BLINKING; pixel_on gated off for 8 frames, on for 8 frames, alternating. Frame 600 -> IDLE, active=0.
- Collected on the same cycle as frame_start while VISIBLE -> IDLE; speed_boost=1 for exactly 300 frames, then 0.
- Spawn at (632,475) -> pixels with DrawX 632–639 and DrawY 475–479 drawn; no wrap hits at DrawX=0–5.
- Reset_n low mid-scan inside the box -> pixel_on=0 and speed_boost=0 asynchronously. With SPEED_PICKUP_STACK_EN, two collections 100 frames apart -> boost lasts 500 frames.

Source files
------------

// File: rtl/speed_pickup_renderer_if.sv
// Pickup renderer bus: game-logic events, VGA scan position, sprite ROM port and draw outputs.
interface speed_pickup_renderer_if;
  logic        frame_start;
  logic        spawn;
  logic [9:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic        collected;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [18:0] rom_addr;
  logic [3:0]  rom_data;
  logic        pixel_on;
  logic [3:0]  pixel_idx;
  logic        active;
  logic        speed_boost;

  modport master (
    output frame_start, spawn, spawn_x, spawn_y, collected, DrawX, DrawY, rom_data,
    input  rom_addr, pixel_on, pixel_idx, active, speed_boost
  );

  modport slave (
    input  frame_start, spawn, spawn_x, spawn_y, collected, DrawX, DrawY, rom_data,
    output rom_addr, pixel_on, pixel_idx, active, speed_boost
  );
endinterface

// File: rtl/speed_pickup_renderer.sv
// Speed power-up lifecycle FSM, boost timer and 1-clock ROM-aligned sprite renderer.
// Define SPEED_PICKUP_STACK_EN to let repeat collections stack boost time.
module speed_pickup_renderer #(
  parameter int unsigned SPR_W           = 14,
  parameter int unsigned SPR_H           = 20,
  parameter int unsigned TRANSP_IDX      = 0,
  parameter int unsigned LIFETIME_FRAMES = 600,
  parameter int unsigned BLINK_FRAMES    = 120,
  parameter int unsigned BLINK_PERIOD    = 8,
  parameter int unsigned BOOST_FRAMES    = 300
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  speed_pickup_renderer_if.slave  bus
);

  localparam int unsigned LIFE_W  = $clog2(LIFETIME_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_PERIOD + 1);
`ifdef SPEED_PICKUP_STACK_EN
  localparam int unsigned BOOST_MAX = 2 * BOOST_FRAMES;
`else
  localparam int unsigned BOOST_MAX = BOOST_FRAMES;
`endif
  localparam int unsigned BOOST_W = $clog2(BOOST_MAX + 1);

  typedef enum logic [1:0] {IDLE, VISIBLE, BLINKING} state_t;

  state_t               state_q;
  logic [9:0]           pos_x_q, pos_y_q;
  logic [LIFE_W-1:0]    life_cnt_q;
  logic [BLINK_W-1:0]   blink_cnt_q;
  logic                 blink_phase_q;
  logic [BOOST_W-1:0]   boost_cnt_q, boost_cnt_d;
  logic                 speed_boost_q;
  logic                 active_q;
  logic                 hit_q, hit_d;

  logic                 in_box;
  logic [10:0]          x_end, y_end;
  logic [9:0]           dx, dy;
  logic [18:0]          addr;
  logic                 collect_hit;
  logic [LIFE_W-1:0]    life_dec;
  logic [BLINK_W-1:0]   blink_dec;

  assign collect_hit = bus.collected && (state_q != IDLE);
  assign life_dec    = life_cnt_q - 1'b1;
  assign blink_dec   = blink_cnt_q - 1'b1;

  // Bounds in 11 bits so a sprite near the right/bottom edge clips instead of wrapping to 0.
  always_comb begin
    x_end  = {1'b0, pos_x_q} + 11'(SPR_W);
    y_end  = {1'b0, pos_y_q} + 11'(SPR_H);
    in_box = (bus.DrawX >= pos_x_q) && ({1'b0, bus.DrawX} < x_end) &&
             (bus.DrawY >= pos_y_q) && ({1'b0, bus.DrawY} < y_end);
    dx     = bus.DrawX - pos_x_q;
    dy     = bus.DrawY - pos_y_q;
    addr   = 19'(dy) * 19'(SPR_W) + 19'(dx);
    hit_d  = in_box && ((state_q == VISIBLE) || ((state_q == BLINKING) && blink_phase_q));
  end

  assign bus.rom_addr = (in_box && Reset_n) ? addr : '0;

  always_comb begin
    logic [BOOST_W:0] boost_sum;
    boost_sum   = {1'b0, boost_cnt_q} + (BOOST_W + 1)'(BOOST_FRAMES);
    boost_cnt_d = boost_cnt_q;
    if (collect_hit) begin
`ifdef SPEED_PICKUP_STACK_EN
      if (speed_boost_q)
        boost_cnt_d = (boost_sum > (BOOST_W + 1)'(BOOST_MAX)) ? BOOST_W'(BOOST_MAX)
                                                              : boost_sum[BOOST_W-1:0];
      else
        boost_cnt_d = BOOST_W'(BOOST_FRAMES);
`else
      boost_cnt_d = BOOST_W'(BOOST_FRAMES);
`endif
    end else if (bus.frame_start && (boost_cnt_q != '0)) begin
      boost_cnt_d = boost_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      life_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      boost_cnt_q   <= '0;
      speed_boost_q <= 1'b0;
      active_q      <= 1'b0;
      hit_q         <= 1'b0;
    end else begin
      hit_q         <= hit_d;
      boost_cnt_q   <= boost_cnt_d;
      speed_boost_q <= (boost_cnt_d != '0);
      // Spawn outranks collection and frame ticks; collection outranks frame ticks.
      if (bus.spawn) begin
        state_q    <= VISIBLE;
        active_q   <= 1'b1;
        pos_x_q    <= bus.spawn_x;
        pos_y_q    <= bus.spawn_y;
        life_cnt_q <= LIFE_W'(LIFETIME_FRAMES);
      end else if (collect_hit) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
      end else if (bus.frame_start) begin
        case (state_q)
          VISIBLE: begin
            life_cnt_q <= life_dec;
            if (life_dec == LIFE_W'(BLINK_FRAMES)) begin
              state_q       <= BLINKING;
              blink_phase_q <= 1'b1;
              blink_cnt_q   <= BLINK_W'(BLINK_PERIOD);
            end
          end
          BLINKING: begin
            life_cnt_q <= life_dec;
            if (blink_dec == '0) begin
              blink_phase_q <= ~blink_phase_q;
              blink_cnt_q   <= BLINK_W'(BLINK_PERIOD);
            end else begin
              blink_cnt_q <= blink_dec;
            end
            if (life_dec == '0) begin
              state_q  <= IDLE;
              active_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pixel_on    = hit_q && (bus.rom_data != 4'(TRANSP_IDX));
  assign bus.pixel_idx   = bus.pixel_on ? bus.rom_data : '0;
  assign bus.active      = active_q;
  assign bus.speed_boost = speed_boost_q;

endmodule
